uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  UART receiver: 8N1, LSB first, 16x oversampling with 3-sample majority vote.
//  Upstream stage of the demo: recovers bytes from the serial line and feeds demo_control_module (data/key path).
//  Its baud_set encoding is the one the transmitter uses, so both ends are configured alike.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  system clock frequency; used to derive the oversample dividers
// PORTS
//  clk        in   1  system clock (50 MHz); single clock domain
//  rst        in   1  synchronous, active-high reset
//  baud_set   in   4  0:9600 1:19200 2:38400 3:57600 4:115200; any other value selects 9600
//  rs232_rx   in   1  asynchronous serial line; idle high
//  rx_data    out  8  last correctly framed byte; holds until the next good frame
//  rx_done    out  1  one-cycle pulse; rx_data is valid in the same cycle
//  frame_err  out  1  one-cycle pulse; stop bit sampled low, byte discarded
//  busy       out  1  high in START, DATA and STOP
// BEHAVIOUR
//  Reset values: rx_data=8'h00, rx_done=0, frame_err=0, busy=0, state=IDLE, armed=0, all counters=0.
//  Input path:
//   - rs232_rx passes through a 2-FF synchronizer (rx_s); nothing else samples the raw line.
//  Divider:
//   - DIV = (CLK_FREQ_HZ + baud*8) / (baud*16), giving 326/163/81/54/27 at 50 MHz.
//   - DIV is latched from baud_set only in IDLE; changes mid-frame are ignored.
//   - Tick counter counts 0..DIV-1; tick pulses when count==DIV-1.
//   - The tick counter clears on start detect to align phase.
//  Bit timing:
//   - sample_cnt (4 bits) advances on each tick; one bit lasts 16 ticks.
//   - Samples are taken on ticks with sample_cnt = 7, 8 and 9.
//   - Bit value = majority of the three samples.
//  State machine:
//   - IDLE:  armed<=1 while rx_s==1. If armed and rx_s==0: go to START, clear tick counter and sample_cnt.
//   - START: majority vote at sample_cnt 9. If the vote is 1 (glitch), go to IDLE with armed kept at 1.
//            Otherwise stay in START until sample_cnt wraps from 15, then go to DATA with bit_idx=0.
//   - DATA:  shift the voted bit into shreg[bit_idx] (LSB first). At the end of each bit period,
//            bit_idx++. After bit 7 completes, go to STOP.
//   - STOP:  vote at sample_cnt 9. If the vote is 1: rx_data<=shreg and rx_done=1 on the next cycle.
//            If the vote is 0: frame_err=1 on the next cycle, rx_data unchanged, armed<=0.
//            In both cases return to IDLE the same cycle as the pulse. The remaining half stop bit is
//            not waited for, so a back-to-back start bit is caught.
//  Latency: rx_done asserts 1 clk after the tick carrying stop-bit sample 9, about 9.5 bit times
//           after the start edge plus 2 synchronizer cycles.
//  Boundary conditions:
//   - Line held low after reset: armed=0, so nothing is received until the line is seen high.
//   - Break or framing error: the receiver needs rx_s==1 again before the next start; no spurious frames.
//   - rx_done and frame_err are mutually exclusive and never longer than 1 cycle.
//   - rst mid-frame: everything returns to reset values on the next edge; a partial byte is never
//     output, and the previous rx_data is cleared to 0.
// STRUCTURE
//  Shared include uart_defs.vh:
//   - baud_set codes (BAUD_9600..BAUD_115200)
//   - oversample constants (OVS=16, SAMPLE_LO=7, SAMPLE_HI=9)
//   - rx state encoding (IDLE/START/DATA/STOP, 2 bits)
//   - the DIV function, reused by the transmitter.
//  Sub-module uart_baud_tick: baud_set latch, divider table, tick counter, sync clear input.
//  Top level: synchronizer, FSM, vote logic, shift register, output registers.
// TESTING
//  1. baud_set=4, send 0x55 8N1 -> one rx_done, rx_data=0x55, frame_err never set, busy low afterwards.
//  2. baud_set=0, 0x00 then 0xFF back-to-back with a single stop bit -> two rx_done pulses,
//     values 0x00 then 0xFF.
//  3. 3-tick low glitch on an idle line (baud 115200) -> busy pulses, then returns to IDLE;
//     no rx_done or frame_err.
//  4. Good 0x3C, then 0xA3 with the stop bit forced 0 -> frame_err once, rx_data stays 0x3C.
//     Line held low 20 bit times -> no events. Then 0x81 -> rx_done, rx_data=0x81.
//  5. rst asserted for 1 cycle during bit 4 of 0x7E -> no rx_done, rx_data=0x00.
//     The next full 0x7E is received correctly.
//  6. baud_set changed 4->0 mid-frame at 115200 -> the current byte is received correctly at 115200.
//     The next byte is received correctly at 9600.
//  All cases: a ±2% baud skew on the stimulus still yields correct data.

Source files
------------

// File: rtl/uart_rx_frame_pkg.sv
// Shared UART definitions: baud codes, oversampling constants, receiver
// state encoding and the oversample divider function used by both ends.
package uart_rx_frame_pkg;

  localparam logic [3:0] BAUD_9600   = 4'd0;
  localparam logic [3:0] BAUD_19200  = 4'd1;
  localparam logic [3:0] BAUD_38400  = 4'd2;
  localparam logic [3:0] BAUD_57600  = 4'd3;
  localparam logic [3:0] BAUD_115200 = 4'd4;

  localparam int         OVS         = 16;
  localparam logic [3:0] SAMPLE_LO   = 4'd7;
  localparam logic [3:0] SAMPLE_MID  = 4'd8;
  localparam logic [3:0] SAMPLE_HI   = 4'd9;
  localparam logic [3:0] SAMPLE_LAST = 4'(OVS - 1);

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Baud rate for a baud_set code; unknown codes fall back to 9600.
  function automatic int unsigned baud_rate(input logic [3:0] code);
    case (code)
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      BAUD_115200: return 115200;
      default:     return 9600;
    endcase
  endfunction

  // Clocks per oversample tick, rounded to nearest.
  function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz,
                                                input logic [3:0]  code);
    int unsigned rate;
    rate = baud_rate(code);
    return DIV_W'((clk_hz + rate * 8) / (rate * 16));
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_frame_baud_tick.sv
// Oversample tick generator: latches the divisor while the receiver is idle
// and produces a one-cycle tick every DIV clocks, realignable by clear.
module uart_rx_frame_baud_tick
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] baud_set,
  input  logic       latch_en,
  input  logic       clear,
  output logic       tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] tick_cnt;

  // Divisor only follows baud_set while idle so a frame keeps one rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= baud_div(CLK_FREQ_HZ, BAUD_9600);
    end else if (latch_en) begin
      div_q <= baud_div(CLK_FREQ_HZ, baud_set);
    end
  end

  // Tick counter; clear restarts the phase at the start edge, and the >= wrap
  // recovers if a smaller divisor is latched while the count is already high.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tick_cnt <= '0;
    end else if (tick_cnt >= div_q - 1'b1) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == div_q - 1'b1);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver, 8N1 LSB first, 16x oversampling with a 3-sample majority
// vote per bit. Delivers each good byte with a one-cycle rx_done pulse and
// flags a low stop bit with a one-cycle frame_err pulse.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] baud_set,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  logic      rx_meta;
  logic      rx_s;
  rx_state_t state;
  logic      armed;
  logic [3:0] sample_cnt;
  logic [2:0] bit_idx;
  logic [1:0] samples;
  logic [7:0] shreg;
  logic      tick;
  logic      start_det;
  logic      vote;

  assign start_det = (state == IDLE) && armed && !rx_s;
  assign vote      = majority3(samples[0], samples[1], rx_s);

  // Two-flop synchronizer; rx_s is the only view of the line in the design.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
    end else begin
      rx_meta <= rs232_rx;
      rx_s    <= rx_meta;
    end
  end

  uart_rx_frame_baud_tick #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_baud_tick (
    .clk      (clk),
    .rst      (rst),
    .baud_set (baud_set),
    .latch_en (state == IDLE),
    .clear    (start_det),
    .tick     (tick)
  );

  // Receive FSM with sample capture, shift register and registered outputs;
  // the stop decision is made at sample 9 so a back-to-back start is caught.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      armed      <= 1'b0;
      sample_cnt <= '0;
      bit_idx    <= '0;
      samples    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;

      if (tick && (state != IDLE)) begin
        sample_cnt <= sample_cnt + 4'd1;
        if (sample_cnt == SAMPLE_LO)  samples[0] <= rx_s;
        if (sample_cnt == SAMPLE_MID) samples[1] <= rx_s;
      end

      case (state)
        IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (start_det) begin
            state      <= START;
            sample_cnt <= '0;
            busy       <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if ((sample_cnt == SAMPLE_HI) && vote) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (sample_cnt == SAMPLE_LAST) begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (sample_cnt == SAMPLE_HI) shreg[bit_idx] <= vote;
            if (sample_cnt == SAMPLE_LAST) begin
              if (bit_idx == 3'd7) state   <= STOP;
              else                 bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        STOP: begin
          if (tick && (sample_cnt == SAMPLE_HI)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_idx <= '0;
            if (vote) begin
              rx_data <= shreg;
              rx_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              armed     <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomized scoreboard bench for uart_rx_frame: the stimulus side builds
// serial frames from bytes and queues the expected receiver events; a
// separate monitor pops and compares whenever rx_done or frame_err fires.
module tb_uart_rx_frame;

  // A clock whose dividers are exact keeps the 9600-baud cases short.
  localparam int CLK_HZ = 9_216_000;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [3:0] baud_set = 4'd4;
  logic       rs232_rx = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  uart_rx_frame #(
    .CLK_FREQ_HZ(CLK_HZ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_set  (baud_set),
    .rs232_rx  (rs232_rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_compared = 0;
  int         n_failed   = 0;
  logic [7:0] last_good  = 8'h00;
  bit         busy_seen  = 1'b0;

  // Clocks per serial bit for a baud code, stretched by skew in parts per thousand.
  function automatic int bit_cycles(input logic [3:0] code, input int skew_pm);
    int rate;
    case (code)
      4'd1:    rate = 19200;
      4'd2:    rate = 38400;
      4'd3:    rate = 57600;
      4'd4:    rate = 115200;
      default: rate = 9600;
    endcase
    return (CLK_HZ / rate) * (1000 + skew_pm) / 1000;
  endfunction

  function automatic int rand_skew();
    return int'($urandom_range(0, 40)) - 20;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic holdLine(input logic level, input int cycles);
    rs232_rx = level;
    repeat (cycles) @(negedge clk);
  endtask

  // Drives one 8N1 frame. rst_bit >= 0 pulses reset midway through that data
  // bit and abandons the frame (line back to idle); switch_bit >= 0 changes
  // baud_set at the start of that data bit.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                               input int bc, input int rst_bit,
                               input int switch_bit, input logic [3:0] switch_code);
    logic [9:0] frame;
    frame = {stop_val, data, 1'b0};
    if (rst_bit < 0) begin
      if (stop_val) begin
        sb.push_back('{is_err: 1'b0, data: data});
        last_good = data;
      end else begin
        sb.push_back('{is_err: 1'b1, data: last_good});
      end
    end
    for (int i = 0; i < 10; i++) begin
      if ((switch_bit >= 0) && (i - 1 == switch_bit)) baud_set = switch_code;
      rs232_rx = frame[i];
      if ((rst_bit >= 0) && (i - 1 == rst_bit)) begin
        repeat (bc / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        last_good = 8'h00;
        rs232_rx  = 1'b1;
        return;
      end
      repeat (bc) @(negedge clk);
    end
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every reported event must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (rx_done || frame_err) begin
        if (sb.size() == 0) begin
          n_compared++;
          n_failed++;
          $display("[TB] FAIL unexpected_event: got done=%0b err=%0b data=%02h, expected no event",
                   rx_done, frame_err, rx_data);
        end else begin
          e = sb.pop_front();
          checkOutput("event_kind", {30'd0, rx_done, frame_err}, e.is_err ? 32'd1 : 32'd2);
          checkOutput("rx_data_at_event", {24'd0, rx_data}, {24'd0, e.data});
        end
      end
    end
  end

  initial begin
    int   bc;
    int   bc2;
    logic stop_val;

    // Reset with the line low, then keep it low: the receiver must stay unarmed.
    rs232_rx = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'h00);
    checkOutput("reset_rx_done", {31'd0, rx_done}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    busy_seen = 1'b0;
    bc = bit_cycles(4'd4, 0);
    holdLine(1'b0, 3 * bc);
    checkOutput("low_after_reset_no_busy", {31'd0, busy_seen}, 32'd0);
    waitDrain(10);
    holdLine(1'b1, 2 * bc);

    $display("[TB] case 1: 0x55 at 115200");
    baud_set = 4'd4;
    bc = bit_cycles(4'd4, rand_skew());
    applyStimulus(8'h55, 1'b1, bc, -1, -1, 4'd0);
    waitDrain(4 * bc);
    checkOutput("busy_after_frame", {31'd0, busy}, 32'd0);

    $display("[TB] case 2: 0x00 then 0xFF back-to-back at 9600");
    baud_set = 4'd0;
    bc = bit_cycles(4'd0, rand_skew());
    holdLine(1'b1, 2 * bc);
    applyStimulus(8'h00, 1'b1, bc, -1, -1, 4'd0);
    applyStimulus(8'hFF, 1'b1, bc, -1, -1, 4'd0);
    waitDrain(4 * bc);

    $display("[TB] case 3: 3-tick glitch at 115200");
    baud_set = 4'd4;
    bc = bit_cycles(4'd4, 0);
    holdLine(1'b1, 2 * bc);
    busy_seen = 1'b0;
    holdLine(1'b0, 3 * (bc / 16));
    holdLine(1'b1, 2 * bc);
    checkOutput("glitch_busy_pulsed", {31'd0, busy_seen}, 32'd1);
    checkOutput("glitch_busy_cleared", {31'd0, busy}, 32'd0);
    waitDrain(10);

    $display("[TB] case 4: framing error, long break, recovery");
    bc = bit_cycles(4'd4, rand_skew());
    applyStimulus(8'h3C, 1'b1, bc, -1, -1, 4'd0);
    applyStimulus(8'hA3, 1'b0, bc, -1, -1, 4'd0);
    holdLine(1'b0, 20 * bc);
    waitDrain(10);
    checkOutput("rx_data_held_after_err", {24'd0, rx_data}, {24'd0, last_good});
    holdLine(1'b1, 2 * bc);
    applyStimulus(8'h81, 1'b1, bc, -1, -1, 4'd0);
    waitDrain(4 * bc);
    checkOutput("rx_data_after_recovery", {24'd0, rx_data}, {24'd0, last_good});

    $display("[TB] case 5: reset during bit 4 of 0x7E");
    holdLine(1'b1, 2 * bc);
    applyStimulus(8'h7E, 1'b1, bc, 4, -1, 4'd0);
    holdLine(1'b1, 12 * bc);
    waitDrain(10);
    checkOutput("rx_data_cleared_by_reset", {24'd0, rx_data}, {24'd0, last_good});
    checkOutput("busy_after_reset", {31'd0, busy}, 32'd0);
    applyStimulus(8'h7E, 1'b1, bc, -1, -1, 4'd0);
    waitDrain(4 * bc);

    $display("[TB] case 6: baud_set 4->0 mid-frame");
    baud_set = 4'd4;
    holdLine(1'b1, 2 * bc);
    bc = bit_cycles(4'd4, rand_skew());
    applyStimulus(8'hC5, 1'b1, bc, -1, 3, 4'd0);
    bc2 = bit_cycles(4'd0, rand_skew());
    holdLine(1'b1, bc2);
    applyStimulus(8'h5A, 1'b1, bc2, -1, -1, 4'd0);
    waitDrain(4 * bc2);

    $display("[TB] random frames");
    stop_val = 1'b1;
    for (int n = 0; n < 8; n++) begin
      baud_set = 4'($urandom_range(2, 4));
      bc = bit_cycles(baud_set, rand_skew());
      // After a framing error the line must be seen high before a new start.
      holdLine(1'b1, (stop_val ? int'($urandom_range(0, 2)) : 1 + int'($urandom_range(0, 1))) * bc);
      stop_val = ($urandom_range(0, 5) != 0);
      applyStimulus(8'($urandom), stop_val, bc, -1, -1, 4'd0);
    end
    holdLine(1'b1, bc);
    waitDrain(4 * bc);
    checkOutput("final_rx_data", {24'd0, rx_data}, {24'd0, last_good});
    checkOutput("final_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
